// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one memory port between the CPU control path and a
// secondary bus master (DMA/debug). One access in flight at a time,
// round-robin on ties, one-cycle ack plus shared read data to the winner.
module mem_arbiter #(
   parameter int ADDR_WIDTH = 16,
   parameter int DATA_WIDTH = 32
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  cpu_req,
   input  logic                  cpu_wr,
   input  logic [ADDR_WIDTH-1:0] cpu_addr,
   input  logic [DATA_WIDTH-1:0] cpu_wdata,
   output logic                  cpu_ack,
   input  logic                  dma_req,
   input  logic                  dma_wr,
   input  logic [ADDR_WIDTH-1:0] dma_addr,
   input  logic [DATA_WIDTH-1:0] dma_wdata,
   output logic                  dma_ack,
   output logic [DATA_WIDTH-1:0] rdata,
   output logic                  mem_rd,
   output logic                  mem_wr,
   output logic [ADDR_WIDTH-1:0] mem_addr,
   output logic [DATA_WIDTH-1:0] mem_wdata,
   input  logic [DATA_WIDTH-1:0] mem_rdata,
   input  logic                  mem_ready,
   output logic                  busy
);

   typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

   state_t                state_q, state_d;
   logic                  own_q, own_d;     // 0 = CPU, 1 = DMA
   logic                  last_q, last_d;   // owner of the last completed access
   logic                  wr_q, wr_d;
   logic [ADDR_WIDTH-1:0] addr_q, addr_d;
   logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
   logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
   logic                  pick_dma;

   // Winner: a lone requester wins; on a tie the master that did not go last wins.
   always_comb begin
      pick_dma = dma_req & (~cpu_req | ~last_q);
   end

   // Next-state: latch the winner in IDLE, wait for mem_ready in BUSY, ack in DONE.
   always_comb begin
      state_d = state_q;
      own_d   = own_q;
      last_d  = last_q;
      wr_d    = wr_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      rdata_d = rdata_q;
      case (state_q)
         IDLE: begin
            if (cpu_req | dma_req) begin
               own_d   = pick_dma;
               wr_d    = pick_dma ? dma_wr    : cpu_wr;
               addr_d  = pick_dma ? dma_addr  : cpu_addr;
               wdata_d = pick_dma ? dma_wdata : cpu_wdata;
               state_d = BUSY;
            end
         end
         BUSY: begin
            if (mem_ready) begin
               if (!wr_q) rdata_d = mem_rdata;
               last_d  = own_q;
               state_d = DONE;
            end
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // State and datapath registers; last resets to DMA so the CPU wins the first tie.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         own_q   <= 1'b0;
         last_q  <= 1'b1;
         wr_q    <= 1'b0;
         addr_q  <= '0;
         wdata_q <= '0;
         rdata_q <= '0;
      end else begin
         state_q <= state_d;
         own_q   <= own_d;
         last_q  <= last_d;
         wr_q    <= wr_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         rdata_q <= rdata_d;
      end
   end

   // Outputs decode from state and latched registers only, never from req/ready.
   assign busy      = (state_q == BUSY);
   assign mem_rd    = busy & ~wr_q;
   assign mem_wr    = busy & wr_q;
   assign mem_addr  = addr_q;
   assign mem_wdata = wdata_q;
   assign cpu_ack   = (state_q == DONE) & ~own_q;
   assign dma_ack   = (state_q == DONE) & own_q;
   assign rdata     = rdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed scenarios plus randomized two-master traffic.
// Expectations go into per-master queues at issue time; a monitor pops them on acks.
module tb_mem_arbiter;
   localparam int AW = 16;
   localparam int DW = 32;

   logic          clk = 1'b0;
   logic          rst;
   logic          cpu_req, cpu_wr, dma_req, dma_wr;
   logic [AW-1:0] cpu_addr, dma_addr;
   logic [DW-1:0] cpu_wdata, dma_wdata;
   logic          cpu_ack, dma_ack;
   logic [DW-1:0] rdata;
   logic          mem_rd, mem_wr;
   logic [AW-1:0] mem_addr;
   logic [DW-1:0] mem_wdata, mem_rdata;
   logic          mem_ready, busy;

   mem_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
      .clk(clk), .rst(rst),
      .cpu_req(cpu_req), .cpu_wr(cpu_wr), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_ack(cpu_ack),
      .dma_req(dma_req), .dma_wr(dma_wr), .dma_addr(dma_addr), .dma_wdata(dma_wdata), .dma_ack(dma_ack),
      .rdata(rdata), .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_rdata(mem_rdata), .mem_ready(mem_ready), .busy(busy)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic          wr;
      logic [DW-1:0] data;
   } exp_t;

   exp_t          cpu_q[$];
   exp_t          dma_q[$];
   exp_t          mon_e;
   logic [DW-1:0] ref_mem [logic [AW-1:0]];    // reference view of memory contents
   logic [DW-1:0] mem_store [logic [AW-1:0]];  // the memory device's own storage
   logic [DW-1:0] exp_rdata = '0;
   int            checks = 0;
   int            errors = 0;
   int            cyc = 0;
   int            mem_mode = 0;                 // 0: ready always 1, 1: fixed wait, 2: random wait
   int            wait_n = 1;
   int            wcnt = 0;
   int            cur_wait = 1;
   logic          prev_strobe = 1'b0;
   logic [AW-1:0] prev_addr = '0;
   logic [DW-1:0] prev_wdata = '0;

   function automatic logic [DW-1:0] fill(input logic [AW-1:0] a);
      return {16'hA5C3, a};
   endfunction

   task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Memory device: wait-state counter and read data, updated away from the active edge.
   always @(negedge clk) begin
      if (mem_rd | mem_wr) wcnt++;
      else wcnt = 0;
      if (wcnt == 1) cur_wait = (mem_mode == 2) ? int'($urandom_range(1, 4)) : wait_n;
      if (mem_mode == 0) mem_ready = 1'b1;
      else mem_ready = (wcnt != 0) && (wcnt >= cur_wait);
      mem_rdata = mem_store.exists(mem_addr) ? mem_store[mem_addr] : fill(mem_addr);
   end

   // Memory device commits writes on the completing edge.
   always @(posedge clk) begin
      cyc++;
      if (mem_wr && mem_ready) mem_store[mem_addr] = mem_wdata;
   end

   // Monitor: memory-side protocol checks and scoreboard pops on every ack.
   always @(negedge clk) begin
      if (rst) begin
         prev_strobe = 1'b0;
      end else begin
         if (mem_rd | mem_wr) begin
            chk("strobe_exclusive", {31'b0, mem_rd & mem_wr}, '0);
            if (prev_strobe) begin
               chk("addr_stable", {16'b0, mem_addr}, {16'b0, prev_addr});
               if (mem_wr) chk("wdata_stable", mem_wdata, prev_wdata);
            end
            chk("access_matches_requester",
                {31'b0, (cpu_req && mem_addr == cpu_addr && mem_wr == cpu_wr && (!mem_wr || mem_wdata == cpu_wdata)) ||
                        (dma_req && mem_addr == dma_addr && mem_wr == dma_wr && (!mem_wr || mem_wdata == dma_wdata))},
                32'd1);
         end
         prev_strobe = mem_rd | mem_wr;
         prev_addr   = mem_addr;
         prev_wdata  = mem_wdata;
         if (cpu_ack && dma_ack) chk("ack_exclusive", 32'd1, 32'd0);
         if (cpu_ack) begin
            if (cpu_q.size() == 0) chk("cpu_spurious_ack", 32'd1, 32'd0);
            else begin
               mon_e = cpu_q.pop_front();
               if (!mon_e.wr) exp_rdata = mon_e.data;
               chk(mon_e.wr ? "cpu_wr_rdata_kept" : "cpu_rdata", rdata, exp_rdata);
            end
         end
         if (dma_ack) begin
            if (dma_q.size() == 0) chk("dma_spurious_ack", 32'd1, 32'd0);
            else begin
               mon_e = dma_q.pop_front();
               if (!mon_e.wr) exp_rdata = mon_e.data;
               chk(mon_e.wr ? "dma_wr_rdata_kept" : "dma_rdata", rdata, exp_rdata);
            end
         end
      end
   end

   // Drive a request for master m (0 = CPU, 1 = DMA) and record the expected response.
   task automatic issue(input bit m, input bit wr, input logic [AW-1:0] a, input logic [DW-1:0] d);
      exp_t e;
      e.wr = wr;
      if (wr) begin
         ref_mem[a] = d;
         e.data = '0;
      end else begin
         e.data = ref_mem.exists(a) ? ref_mem[a] : fill(a);
      end
      if (!m) begin
         cpu_req = 1'b1; cpu_wr = wr; cpu_addr = a; cpu_wdata = d; cpu_q.push_back(e);
      end else begin
         dma_req = 1'b1; dma_wr = wr; dma_addr = a; dma_wdata = d; dma_q.push_back(e);
      end
   endtask

   task automatic wait_ack(input bit m, input bit drop, output int c);
      c = -1;
      for (int i = 0; i < 60; i++) begin
         @(negedge clk);
         if (m ? dma_ack : cpu_ack) begin
            c = cyc;
            break;
         end
      end
      checks++;
      if (c < 0) begin
         errors++;
         $display("FAIL %s_ack_timeout: no ack within 60 cycles, ack required", m ? "dma" : "cpu");
      end
      if (drop) begin
         if (m) dma_req = 1'b0;
         else cpu_req = 1'b0;
      end
   endtask

   // Returns 0 for a CPU ack, 1 for a DMA ack, -1 on timeout.
   task automatic wait_any(output int who, output int c);
      who = -1;
      c = -1;
      for (int i = 0; i < 30; i++) begin
         @(negedge clk);
         if (cpu_ack | dma_ack) begin
            who = dma_ack ? 1 : 0;
            c = cyc;
            break;
         end
      end
      checks++;
      if (who < 0) begin
         errors++;
         $display("FAIL any_ack_timeout: no ack within 30 cycles, ack required");
      end
   endtask

   task automatic do_reset();
      rst = 1'b1;
      cpu_req = 1'b0;
      dma_req = 1'b0;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      cpu_q.delete();
      dma_q.delete();
      exp_rdata = '0;
   endtask

   task automatic rand_txn(input bit m);
      int            gap, c;
      logic [AW-1:0] a;
      gap = $urandom_range(0, 3);
      repeat (gap) @(negedge clk);
      a = m ? AW'(16'h0100 + $urandom_range(0, 15)) : AW'($urandom_range(0, 15));
      issue(m, 1'($urandom_range(0, 1)), a, $urandom);
      wait_ack(m, 1'b1, c);
   endtask

   initial begin
      int c0, c1, who, lastc, cnt;
      rst = 1'b1;
      cpu_req = 0; cpu_wr = 0; cpu_addr = '0; cpu_wdata = '0;
      dma_req = 0; dma_wr = 0; dma_addr = '0; dma_wdata = '0;
      mem_ready = 1'b0; mem_rdata = '0;
      mem_store[16'h0010] = 32'hDEADBEEF;
      ref_mem[16'h0010]   = 32'hDEADBEEF;
      repeat (3) @(negedge clk);

      // Reset state
      chk("rst_busy", {31'b0, busy}, '0);
      chk("rst_mem_rd", {31'b0, mem_rd}, '0);
      chk("rst_mem_wr", {31'b0, mem_wr}, '0);
      chk("rst_acks", {30'b0, cpu_ack, dma_ack}, '0);
      chk("rst_mem_addr", {16'b0, mem_addr}, '0);
      chk("rst_mem_wdata", mem_wdata, '0);
      chk("rst_rdata", rdata, '0);
      rst = 1'b0;

      // CPU read, zero-wait memory: strobe in N+1, ack in N+2
      mem_mode = 0;
      issue(1'b0, 1'b0, 16'h0010, '0);
      @(negedge clk);
      chk("cpu_rd_strobe", {31'b0, mem_rd}, 32'd1);
      chk("cpu_rd_addr", {16'b0, mem_addr}, 32'h0010);
      chk("cpu_rd_busy", {31'b0, busy}, 32'd1);
      @(negedge clk);
      chk("cpu_rd_ack", {31'b0, cpu_ack}, 32'd1);
      chk("cpu_rd_strobe_low", {31'b0, mem_rd}, '0);
      chk("cpu_rd_dma_ack", {31'b0, dma_ack}, '0);
      cpu_req = 1'b0;
      @(negedge clk);
      chk("cpu_ack_one_cycle", {31'b0, cpu_ack}, '0);

      // DMA write with 3-cycle memory wait
      mem_mode = 1; wait_n = 3;
      issue(1'b1, 1'b1, 16'h0020, 32'h12345678);
      cnt = 0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (dma_ack) break;
         if (mem_wr) cnt++;
      end
      chk("dma_wr_strobe_cycles", cnt, 32'd3);
      chk("dma_wr_ack", {31'b0, dma_ack}, 32'd1);
      chk("dma_wr_rdata_unchanged", rdata, 32'hDEADBEEF);
      dma_req = 1'b0;

      // Both held after reset: CPU, DMA, CPU, DMA, 3 cycles apart
      do_reset();
      mem_mode = 0;
      issue(1'b0, 1'b0, 16'h0010, '0);
      issue(1'b0, 1'b0, 16'h0010, '0);
      issue(1'b1, 1'b0, 16'h0020, '0);
      issue(1'b1, 1'b0, 16'h0020, '0);
      lastc = 0;
      for (int k = 0; k < 4; k++) begin
         wait_any(who, c0);
         chk("tie_order", who, k % 2);
         if (k > 0) chk("tie_spacing", c0 - lastc, 32'd3);
         lastc = c0;
      end
      cpu_req = 1'b0;
      dma_req = 1'b0;

      // CPU request while DMA is busy waits for the DMA ack
      @(negedge clk);
      mem_mode = 1; wait_n = 3;
      issue(1'b1, 1'b0, 16'h0020, '0);
      @(negedge clk);
      issue(1'b0, 1'b0, 16'h0030, '0);
      wait_ack(1'b1, 1'b1, c1);
      wait_ack(1'b0, 1'b1, c0);
      chk("cpu_after_dma_gap", c0 - c1, 32'd5);

      // Reset mid-access: strobes drop, no ack, next tie goes to the CPU
      @(negedge clk);
      mem_mode = 1; wait_n = 10;
      issue(1'b0, 1'b0, 16'h0040, '0);
      repeat (2) @(negedge clk);
      chk("pre_rst_busy", {31'b0, busy}, 32'd1);
      rst = 1'b1;
      cpu_req = 1'b0;
      @(negedge clk);
      chk("mid_rst_strobes", {30'b0, mem_rd, mem_wr}, '0);
      chk("mid_rst_busy", {31'b0, busy}, '0);
      chk("mid_rst_acks", {30'b0, cpu_ack, dma_ack}, '0);
      rst = 1'b0;
      cpu_q.delete();
      exp_rdata = '0;
      mem_mode = 0;
      issue(1'b0, 1'b0, 16'h0010, '0);
      issue(1'b1, 1'b0, 16'h0020, '0);
      wait_any(who, c0);
      chk("post_rst_tie_cpu", who, 32'd0);
      cpu_req = 1'b0;
      wait_ack(1'b1, 1'b1, c1);

      // mem_ready high while IDLE with no requests: nothing happens
      @(negedge clk);
      mem_mode = 0;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         chk("idle_ready_busy", {31'b0, busy}, '0);
         chk("idle_ready_acks", {30'b0, cpu_ack, dma_ack}, '0);
         chk("idle_ready_rdata", rdata, exp_rdata);
      end

      // Randomized concurrent traffic, disjoint address ranges per master
      mem_mode = 2;
      @(negedge clk);
      fork
         begin repeat (30) rand_txn(1'b0); end
         begin repeat (30) rand_txn(1'b1); end
      join
      repeat (3) @(negedge clk);
      chk("cpu_q_drained", cpu_q.size(), '0);
      chk("dma_q_drained", dma_q.size(), '0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-requester arbiter that shares the single memory port (`mem_rd`/`mem_wr` bus) between the CPU control path (MAR/MDR transfers) and a secondary bus master (DMA/debug). It latches one request at a time, drives the memory until the memory acknowledges, then returns read data and a one-cycle acknowledge to the winner. Priority is round-robin on ties, so neither master starves. Sits between `control`/MAR/MDR and the memory model.

## Interface
- `ADDR_WIDTH`, 16, memory address width
- `DATA_WIDTH`, 32, memory data width

- `clk`  in  1  system clock, all state on rising edge
- `rst`  in  1  synchronous, active-high reset
- `cpu_req`  in  1  CPU request; held high until `cpu_ack`
- `cpu_wr`  in  1  1 = write, 0 = read; valid while `cpu_req`
- `cpu_addr`  in  ADDR_WIDTH  CPU address
- `cpu_wdata`  in  DATA_WIDTH  CPU write data
- `cpu_ack`  out  1  one-cycle completion pulse to CPU
- `dma_req`, `dma_wr`, `dma_addr`, `dma_wdata`, `dma_ack`: same as the CPU set, for the secondary master
- `rdata`  out  DATA_WIDTH  read data, shared, valid in the ack cycle
- `mem_rd`  out  1  memory read strobe
- `mem_wr`  out  1  memory write strobe
- `mem_addr`  out  ADDR_WIDTH  memory address
- `mem_wdata`  out  DATA_WIDTH  memory write data
- `mem_rdata`  in  DATA_WIDTH  memory read data, valid when `mem_ready`
- `mem_ready`  in  1  memory completes the current access this cycle
- `busy`  out  1  high in BUSY

## Operation
- States: IDLE, BUSY, DONE. Owner register `own` (0 = CPU, 1 = DMA). Last-owner register `last`.
- IDLE: if any `req` is high, pick a winner.
  - Only one request: that requester wins.
  - Both requests: the requester that is not `last` wins.
  - On the edge, latch `own`, `wr`, `addr` and `wdata` from the winner and go to BUSY.
- BUSY: `mem_rd = ~wr_l`, `mem_wr = wr_l`, `mem_addr`/`mem_wdata` come from the latched registers (stable for the whole access).
  - On the edge where `mem_ready` = 1: capture `mem_rdata` into `rdata` (reads only; writes leave `rdata` unchanged), set `last <= own`, go to DONE.
  - Requester inputs are ignored while in BUSY.
- DONE: assert `cpu_ack` if `own` = 0, otherwise `dma_ack`. Requests are ignored this cycle, because the requester lowers `req` here. Go to IDLE.
- A requester that keeps `req` high after its ack is treated as a new request in the following IDLE cycle.
- `mem_rd` and `mem_wr` are never high together. They are both low outside BUSY.
- `mem_ready` outside BUSY is ignored.

## Timing
- Reset values: state IDLE, `last` = 1 (CPU wins the first tie), `cpu_ack` = `dma_ack` = 0, `mem_rd` = `mem_wr` = 0, `busy` = 0, `mem_addr` = 0, `mem_wdata` = 0, `rdata` = 0.
- Outputs are registered or decoded from state only. There is no combinational path from `*_req` or `mem_ready` to any output.
- Latency: `req` first high in cycle N (IDLE) gives strobe high in N+1.
  - `mem_ready` high in cycle M (M ≥ N+1) gives ack and `rdata` valid in M+1, with strobes low in M+1.
  - Zero-wait memory: ack in N+2. Minimum spacing between accesses is 3 cycles.
- `rst` asserted mid-access: in the next cycle the block is in IDLE with strobes low. The pending access gets no ack, and the requester must re-issue it.
- A request arriving in the same cycle the other master's ack is issued waits for the next IDLE cycle.

## Test plan
- CPU read, `cpu_addr` = 0x0010, `mem_ready` tied 1, `mem_rdata` = 0xDEADBEEF -> `mem_rd` high 1 cycle with `mem_addr` = 0x0010; `cpu_ack` pulse 2 cycles after `req`; `rdata` = 0xDEADBEEF; `dma_ack` stays 0.
- DMA write 0x12345678 to 0x0020, `mem_ready` delayed 3 cycles -> `mem_wr` high 3 cycles with address and data stable; `dma_ack` in the cycle after ready; `rdata` unchanged.
- Both requesters held high continuously after reset -> grants alternate CPU, DMA, CPU, DMA; each ack is 3 cycles apart with zero-wait memory.
- CPU request arrives while DMA is BUSY -> the CPU is not granted until after the DMA ack; `mem_addr` does not change mid-access.
- `rst` pulsed during BUSY (`mem_ready` = 0) -> next cycle `mem_rd` = `mem_wr` = 0, `busy` = 0, no ack issued; the next tie goes to the CPU.
- `mem_ready` pulsed while IDLE with no requests -> no state change, no ack, `rdata` unchanged.
